// File: rtl/lbp_pkg.sv
// Shared types and geometry for the LBP gray-image host and core.
package lbp_pkg;

  // Host responder frame state.
  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StServe,
    StDone
  } host_state_t;

  localparam int unsigned LBP_IMG_W = 128;
  localparam int unsigned LBP_IMG_H = 128;
  localparam int unsigned LBP_AW    = 14;
  localparam int unsigned LBP_DW    = 8;

endpackage

// File: rtl/lbp_gray_host_if.sv
// Load stream, gray read port and status of the LBP gray-image host.
interface lbp_gray_host_if #(
  parameter int unsigned AW = lbp_pkg::LBP_AW,
  parameter int unsigned DW = lbp_pkg::LBP_DW
) ();

  logic          load_start;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          gray_ready;
  logic [DW-1:0] gray_data;
  logic          finish;
  logic          busy;
  logic [AW:0]   req_count;
  logic          addr_err;

  // Frame source and LBP engine side.
  modport master (
    output load_start, pix_valid, pix_data, gray_req, gray_addr, finish,
    input  pix_ready, gray_ready, gray_data, busy, req_count, addr_err
  );

  // Host responder side.
  modport slave (
    input  load_start, pix_valid, pix_data, gray_req, gray_addr, finish,
    output pix_ready, gray_ready, gray_data, busy, req_count, addr_err
  );

endinterface

// File: rtl/gray_ram.sv
// Depth x DW image RAM: one synchronous write port, one registered read port with enable.
// Kept standalone so it can be replaced by a memory macro.
module gray_ram #(
  parameter int unsigned Depth = 16384,
  parameter int unsigned AW    = 14,
  parameter int unsigned DW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_q;

  // Write and read ports; callers keep addresses below Depth.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i[IdxW-1:0]] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i[IdxW-1:0]];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lbp_gray_host.sv
// Host responder: loads one gray frame into RAM, then serves LBP core reads until finish.
module lbp_gray_host
  import lbp_pkg::*;
#(
  parameter int unsigned IMG_W = LBP_IMG_W,
  parameter int unsigned IMG_H = LBP_IMG_H,
  parameter int unsigned DEPTH = IMG_W * IMG_H,
  parameter int unsigned AW    = LBP_AW,
  parameter int unsigned DW    = LBP_DW
) (
  input  logic          clk,
  input  logic          reset,
  lbp_gray_host_if.slave bus
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
  localparam logic [AW:0]   CntMax   = '1;

  host_state_t   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   req_cnt_q, req_cnt_d;
  logic          addr_err_q, addr_err_d;
  // Selects RAM data for gray_data; low means the last response was zero.
  logic          rd_valid_q, rd_valid_d;

  logic          in_range;
  logic          load_beat;
  logic          serve_rd;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;

  assign in_range  = {{(32 - AW){1'b0}}, bus.gray_addr} < DEPTH;
  assign load_beat = (state_q == StLoad) && bus.pix_valid;
  assign serve_rd  = (state_q == StServe) && bus.gray_req;
  assign ram_re    = serve_rd && in_range;

  gray_ram #(
    .Depth (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_gray_ram (
    .clk_i   (clk),
    .we_i    (load_beat),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.pix_data),
    .re_i    (ram_re),
    .raddr_i (bus.gray_addr),
    .rdata_o (ram_rdata)
  );

  // Next-state, write pointer, request counter and error flag.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    req_cnt_d  = req_cnt_q;
    addr_err_d = addr_err_q;
    rd_valid_d = rd_valid_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.load_start) begin
          state_d    = StLoad;
          wr_ptr_d   = '0;
          req_cnt_d  = '0;
          addr_err_d = 1'b0;
        end
      end
      StLoad: begin
        if (load_beat) begin
          wr_ptr_d = wr_ptr_q + PtrOne;
          if (wr_ptr_q == LastAddr) begin
            state_d = StServe;
          end
        end
      end
      StServe: begin
        // A read sampled with finish is still served.
        if (serve_rd) begin
          req_cnt_d  = (req_cnt_q == CntMax) ? req_cnt_q : req_cnt_q + CntOne;
          rd_valid_d = in_range;
          if (!in_range) begin
            addr_err_d = 1'b1;
          end
        end
        if (bus.finish) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      req_cnt_q  <= '0;
      addr_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      req_cnt_q  <= req_cnt_d;
      addr_err_q <= addr_err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.pix_ready  = (state_q == StLoad);
  assign bus.gray_ready = (state_q == StServe);
  assign bus.busy       = (state_q == StLoad) || (state_q == StServe);
  assign bus.gray_data  = rd_valid_q ? ram_rdata : '0;
  assign bus.req_count  = req_cnt_q;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_lbp_gray_host.sv
// Randomized self-checking bench for lbp_gray_host against a frame-level reference model.
module tb_lbp_gray_host;
  import lbp_pkg::*;

  localparam int unsigned Depth  = LBP_IMG_W * LBP_IMG_H;
  localparam int unsigned DepthS = 64 * 64;
  localparam int unsigned CntMax = (1 << (LBP_AW + 1)) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset_s = 1'b0;

  always #5 clk = ~clk;

  lbp_gray_host_if bus_m ();
  lbp_gray_host_if bus_s ();

  lbp_gray_host #(
    .IMG_W (LBP_IMG_W),
    .IMG_H (LBP_IMG_H)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  lbp_gray_host #(
    .IMG_W (64),
    .IMG_H (64)
  ) u_dut_s (
    .clk   (clk),
    .reset (reset_s),
    .bus   (bus_s)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model of the 128x128 instance.
  logic [7:0] ref_mem [Depth];
  logic [7:0] ref_s   [DepthS];
  logic [7:0] exp_data = 8'h00;
  int         exp_cnt  = 0;
  bit         exp_err  = 1'b0;
  bit         serving  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_data"}, 32'(bus_m.gray_data), 32'(exp_data));
    check_eq({tag, "_cnt"}, 32'(bus_m.req_count), exp_cnt);
    check_eq({tag, "_err"}, 32'(bus_m.addr_err), 32'(exp_err));
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_pix_ready"}, 32'(bus_m.pix_ready), 0);
    check_eq({tag, "_gray_ready"}, 32'(bus_m.gray_ready), 0);
    check_eq({tag, "_busy"}, 32'(bus_m.busy), 0);
    check_model(tag);
  endtask

  // Request one read at the next edge; gray_req is left high for back-to-back use.
  task automatic read_m(input logic [LBP_AW-1:0] addr);
    bus_m.gray_req  = 1'b1;
    bus_m.gray_addr = addr;
    @(negedge clk);
    if (serving) begin
      if (exp_cnt < CntMax) exp_cnt++;
      if (int'(addr) < Depth) begin
        exp_data = ref_mem[addr];
      end else begin
        exp_data = 8'h00;
        exp_err  = 1'b1;
      end
    end
  endtask

  // Full frame load; abort_at >= 0 applies reset once that many pixels are accepted.
  task automatic load_m(input bit ramp, input int stall_pct, input int abort_at,
                        output int cycles);
    int         i;
    logic [7:0] d;
    bit         v;
    bus_m.load_start = 1'b1;
    @(negedge clk);
    bus_m.load_start = 1'b0;
    serving = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    cycles  = 1;
    i       = 0;
    while (i < int'(Depth) && cycles < 4 * int'(Depth)) begin
      if (abort_at >= 0 && i == abort_at) begin
        bus_m.pix_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_data = 8'h00;
        exp_cnt  = 0;
        exp_err  = 1'b0;
        check_quiet("abort");
        return;
      end
      d = ramp ? 8'(i) : 8'($urandom);
      v = ($urandom_range(99) >= stall_pct);
      bus_m.pix_valid = v;
      bus_m.pix_data  = d;
      if (i == int'(Depth) - 1) check_eq("ready_early", 32'(bus_m.gray_ready), 0);
      if (v && bus_m.pix_ready) begin
        ref_mem[i] = d;
        i++;
      end
      @(negedge clk);
      cycles++;
    end
    bus_m.pix_valid = 1'b0;
    check_eq("load_beats", i, Depth);
    check_eq("load_gray_ready", 32'(bus_m.gray_ready), 1);
    check_eq("load_pix_ready", 32'(bus_m.pix_ready), 0);
    check_eq("load_busy", 32'(bus_m.busy), 1);
    serving = 1'b1;
  endtask

  task automatic finish_m();
    bus_m.finish = 1'b1;
    @(negedge clk);
    bus_m.finish = 1'b0;
    serving = 1'b0;
  endtask

  // Main 128x128 instance sequence.
  task automatic run_main();
    int cycles;
    bus_m.load_start = 1'b0;
    bus_m.pix_valid  = 1'b0;
    bus_m.pix_data   = '0;
    bus_m.gray_req   = 1'b0;
    bus_m.gray_addr  = '0;
    bus_m.finish     = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_quiet("idle");
    read_m(14'd5);
    bus_m.gray_req = 1'b0;
    check_quiet("idle_req");

    // Ramp frame with pix_valid held high.
    load_m(1'b1, 0, -1, cycles);
    check_eq("ramp_latency", cycles, Depth + 1);
    read_m(14'd300);
    bus_m.gray_req = 1'b0;
    check_model("rd300");
    check_eq("rd300_lit", 32'(bus_m.gray_data), 32'h2c);
    @(negedge clk);
    check_model("hold");
    read_m(14'd0);
    check_model("b2b0");
    read_m(14'd1);
    check_model("b2b1");
    read_m(14'd16383);
    bus_m.gray_req = 1'b0;
    check_model("b2b_last");
    check_eq("b2b_last_lit", 32'(bus_m.gray_data), 32'hff);

    // finish and a read in the same cycle.
    bus_m.finish = 1'b1;
    read_m(14'd7);
    bus_m.finish = 1'b0;
    bus_m.gray_req = 1'b0;
    serving = 1'b0;
    check_model("fin_rd");
    check_eq("fin_gray_ready", 32'(bus_m.gray_ready), 0);
    check_eq("fin_busy", 32'(bus_m.busy), 0);
    read_m(14'd300);
    bus_m.gray_req = 1'b0;
    check_model("done_req");

    // Reset mid-load, then a randomized stalled load with full readback.
    load_m(1'b0, 0, 8000, cycles);
    @(negedge clk);
    check_quiet("post_abort");
    load_m(1'b0, 30, -1, cycles);
    for (int a = 0; a < int'(Depth); a++) begin
      read_m(LBP_AW'(a));
      check_eq("readback", 32'(bus_m.gray_data), 32'(exp_data));
    end
    bus_m.gray_req = 1'b0;
    check_model("readback_end");
    check_eq("readback_cnt", 32'(bus_m.req_count), Depth);
    finish_m();
    check_eq("done_ready", 32'(bus_m.gray_ready), 0);

    // Second frame from DONE starts with a fresh counter.
    bus_m.load_start = 1'b1;
    @(negedge clk);
    bus_m.load_start = 1'b0;
    check_eq("frame2_cnt", 32'(bus_m.req_count), 0);
    check_eq("frame2_pix_ready", 32'(bus_m.pix_ready), 1);
    check_eq("frame2_busy", 32'(bus_m.busy), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // 64x64 instance: out-of-range requests and sticky addr_err.
  task automatic run_small();
    int         j;
    int         cyc;
    logic [7:0] d;
    bus_s.load_start = 1'b0;
    bus_s.pix_valid  = 1'b0;
    bus_s.pix_data   = '0;
    bus_s.gray_req   = 1'b0;
    bus_s.gray_addr  = '0;
    bus_s.finish     = 1'b0;
    reset_s = 1'b0;
    repeat (3) @(negedge clk);
    reset_s = 1'b1;
    bus_s.load_start = 1'b1;
    @(negedge clk);
    bus_s.load_start = 1'b0;
    j   = 0;
    cyc = 0;
    while (j < int'(DepthS) && cyc < 2 * int'(DepthS)) begin
      d = 8'($urandom);
      bus_s.pix_valid = 1'b1;
      bus_s.pix_data  = d;
      if (bus_s.pix_ready) begin
        ref_s[j] = d;
        j++;
      end
      @(negedge clk);
      cyc++;
    end
    bus_s.pix_valid = 1'b0;
    check_eq("s_gray_ready", 32'(bus_s.gray_ready), 1);
    bus_s.gray_req  = 1'b1;
    bus_s.gray_addr = 14'd10;
    @(negedge clk);
    check_eq("s_rd10", 32'(bus_s.gray_data), 32'(ref_s[10]));
    check_eq("s_err0", 32'(bus_s.addr_err), 0);
    bus_s.gray_addr = 14'd5000;
    @(negedge clk);
    check_eq("s_oor_data", 32'(bus_s.gray_data), 0);
    check_eq("s_oor_err", 32'(bus_s.addr_err), 1);
    check_eq("s_oor_cnt", 32'(bus_s.req_count), 2);
    bus_s.gray_addr = 14'd20;
    @(negedge clk);
    check_eq("s_rd20", 32'(bus_s.gray_data), 32'(ref_s[20]));
    check_eq("s_sticky", 32'(bus_s.addr_err), 1);
    bus_s.gray_req = 1'b0;
    bus_s.finish   = 1'b1;
    @(negedge clk);
    bus_s.finish = 1'b0;
    check_eq("s_done_err", 32'(bus_s.addr_err), 1);
    bus_s.load_start = 1'b1;
    @(negedge clk);
    bus_s.load_start = 1'b0;
    check_eq("s_restart_err", 32'(bus_s.addr_err), 0);
    check_eq("s_restart_cnt", 32'(bus_s.req_count), 0);
  endtask

  initial begin
    fork
      run_main();
      run_small();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
